edge_task_rs: RTL and testbench



---
 rtl/edge_pkg.sv | 21 ++
 rtl/rs_age_select.sv | 42 ++++
 rtl/edge_task_rs.sv | 136 +++++++++++++
 tb/tb_edge_task_rs.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and defaults for the edge task path (DP decoder -> RS -> edge PEs).
package edge_pkg;

    localparam int EDGE_PKT_W      = 16;
    localparam int EDGE_MAX_ITER   = 4;
    localparam int EDGE_ITER_LSB   = 7;
    localparam int EDGE_STARVE_LIM = 15;
    localparam int WAIT_W          = $clog2(EDGE_STARVE_LIM + 1);

    typedef struct packed {
        logic                  valid;
        logic [EDGE_PKT_W-1:0] packet;
        logic [WAIT_W-1:0]     wait_cnt;
    } rs_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [EDGE_PKT_W-1:0] packet;
    } dispatch_t;

endpackage

// File: rtl/rs_age_select.sv
// Age matrix plus oldest-first selection of up to MAX_DISP candidates.
// Grants are combinational from registered age state; one-hot (or zero) per slot, slot 0 oldest.
module rs_age_select #(
    parameter int DEPTH    = 8,
    parameter int MAX_DISP = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enq,
    input  logic [DEPTH-1:0]               enq_oh,
    input  logic [DEPTH-1:0]               valid,
    input  logic [DEPTH-1:0]               cand,
    output logic [MAX_DISP-1:0][DEPTH-1:0] grant
);

    // older_than[i][j] = 1 when entry j was enqueued before entry i
    logic [DEPTH-1:0] older_than [DEPTH];
    logic [DEPTH-1:0] pool;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) older_than[i] <= '0;
        end else if (enq) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (enq_oh[i]) older_than[i] <= valid;
                else           older_than[i] <= older_than[i] & ~enq_oh;
            end
        end
    end

    always_comb begin
        pool  = cand;
        grant = '0;
        for (int s = 0; s < MAX_DISP; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pool[i] && ((older_than[i] & pool) == '0)) grant[s][i] = 1'b1;
            end
            pool = pool & ~grant[s];
        end
    end

endmodule

// File: rtl/edge_task_rs.sv
// Reservation station buffering DP tasks and issuing up to MAX_DISP per cycle to idle edge PEs.
// Task enqueued at edge N can dispatch at edge N+1 (registered strobe); in_ready drops only when full.
module edge_task_rs
    import edge_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int NUM_PE     = 4,
    parameter int PKT_W      = EDGE_PKT_W,
    parameter int MAX_ITER   = EDGE_MAX_ITER,
    parameter int ITER_LSB   = EDGE_ITER_LSB,
    parameter int MAX_DISP   = 2,
    parameter int STARVE_LIM = EDGE_STARVE_LIM
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PKT_W-1:0]              in_packet,
    input  logic [$clog2(MAX_ITER)-1:0]   replay_iter,
    input  logic [NUM_PE-1:0]             pe_idle,
    input  logic [NUM_PE-1:0]             bank_busy,
    output logic [NUM_PE-1:0]             out_valid,
    output logic [NUM_PE*PKT_W-1:0]       out_packet,
    output logic                          rs_empty,
    output logic                          rs_full,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int IW = $clog2(MAX_ITER);
    localparam int OW = $clog2(DEPTH + 1);

    rs_entry_t                     ent    [DEPTH];
    dispatch_t                     disp_q [NUM_PE];
    dispatch_t                     disp_d [NUM_PE];
    logic [DEPTH-1:0]              valid_vec;
    logic [DEPTH-1:0]              hot;
    logic [DEPTH-1:0]              cand;
    logic [DEPTH-1:0]              enq_oh;
    logic [DEPTH-1:0]              deq_mask;
    logic [MAX_DISP-1:0][DEPTH-1:0] grant;
    logic [NUM_PE-1:0]             elig;
    logic [NUM_PE-1:0]             rem;
    logic [NUM_PE-1:0]             pick_pe;
    logic                          enq;

    // Candidate set: iteration-mask hits and starved entries take precedence unless on the final pass
    always_comb begin
        valid_vec = '0;
        hot       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent[i].valid;
            if (ent[i].valid && (ent[i].wait_cnt == WAIT_W'(STARVE_LIM))) hot[i] = 1'b1;
            for (int m = 0; m < MAX_ITER - 1; m++) begin
                if (ent[i].valid && (replay_iter == IW'(m)) && ent[i].packet[ITER_LSB + m])
                    hot[i] = 1'b1;
            end
        end
        cand = valid_vec;
        if ((replay_iter != IW'(MAX_ITER - 1)) && (hot != '0)) cand = hot;
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OW'(valid_vec[i]);
    end

    assign rs_full  = (occupancy == OW'(DEPTH));
    assign rs_empty = (occupancy == '0);
    assign in_ready = !rs_full;
    assign enq      = in_valid && in_ready;
    assign enq_oh   = ~valid_vec & (valid_vec + DEPTH'(1));

    rs_age_select #(
        .DEPTH    (DEPTH),
        .MAX_DISP (MAX_DISP)
    ) u_age (
        .clk    (clk),
        .reset  (reset),
        .enq    (enq),
        .enq_oh (enq_oh),
        .valid  (valid_vec),
        .cand   (cand),
        .grant  (grant)
    );

    // Slot s pairs with the s-th eligible PE in ascending index order
    always_comb begin
        for (int j = 0; j < NUM_PE; j++) begin
            elig[j]   = pe_idle[j] && !bank_busy[j] && !disp_q[j].valid;
            disp_d[j] = '0;
        end
        rem      = elig;
        pick_pe  = '0;
        deq_mask = '0;
        for (int s = 0; s < MAX_DISP; s++) begin
            pick_pe = rem & (~rem + NUM_PE'(1));
            rem     = rem & ~pick_pe;
            for (int j = 0; j < NUM_PE; j++) begin
                if (pick_pe[j] && (grant[s] != '0)) begin
                    disp_d[j].valid = 1'b1;
                    for (int i = 0; i < DEPTH; i++)
                        if (grant[s][i]) disp_d[j].packet = ent[i].packet;
                end
            end
            if (pick_pe != '0) deq_mask = deq_mask | grant[s];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)  ent[i]    <= '0;
            for (int j = 0; j < NUM_PE; j++) disp_q[j] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (enq && enq_oh[i]) begin
                    ent[i].valid    <= 1'b1;
                    ent[i].packet   <= in_packet;
                    ent[i].wait_cnt <= '0;
                end else if (deq_mask[i]) begin
                    ent[i].valid <= 1'b0;
                end else if (ent[i].valid && (ent[i].wait_cnt != WAIT_W'(STARVE_LIM))) begin
                    ent[i].wait_cnt <= ent[i].wait_cnt + WAIT_W'(1);
                end
            end
            for (int j = 0; j < NUM_PE; j++) disp_q[j] <= disp_d[j];
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_PE; j++) begin
            out_valid[j]                 = disp_q[j].valid;
            out_packet[j*PKT_W +: PKT_W] = disp_q[j].packet;
        end
    end

endmodule

// File: tb/tb_edge_task_rs.sv
// Bench for edge_task_rs: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_edge_task_rs;

    localparam int DEPTH = 8, NUM_PE = 4, PKT_W = 16, MAX_ITER = 4;
    localparam int ITER_LSB = 7, MAX_DISP = 2, STARVE_LIM = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_packet;
    logic [1:0]  replay_iter;
    logic [3:0]  pe_idle;
    logic [3:0]  bank_busy;
    logic [3:0]  out_valid;
    logic [63:0] out_packet;
    logic        rs_empty;
    logic        rs_full;
    logic [3:0]  occupancy;

    always #5 clk = ~clk;

    edge_task_rs #(
        .DEPTH(DEPTH), .NUM_PE(NUM_PE), .PKT_W(PKT_W), .MAX_ITER(MAX_ITER),
        .ITER_LSB(ITER_LSB), .MAX_DISP(MAX_DISP), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_packet(in_packet), .replay_iter(replay_iter), .pe_idle(pe_idle),
        .bank_busy(bank_busy), .out_valid(out_valid), .out_packet(out_packet),
        .rs_empty(rs_empty), .rs_full(rs_full), .occupancy(occupancy)
    );

    int checks = 0;
    int passed = 0;

    // Model: tasks kept in arrival order (front = oldest) with their wait counts
    logic [15:0] q_pkt  [$];
    int          q_wait [$];
    logic [3:0]  m_ov;
    logic [63:0] m_op;

    function automatic logic [15:0] mk(input logic [2:0] mask);
        logic [15:0] p;
        p      = 16'($urandom);
        p[9:7] = mask;
        return p;
    endfunction

    task automatic model_clear();
        q_pkt.delete();
        q_wait.delete();
        m_ov = '0;
        m_op = '0;
    endtask

    task automatic model_step();
        int          elig [$];
        bit          cand [$];
        logic [15:0] np   [$];
        int          nw   [$];
        bit          hot_any, h, acc;
        int          picks;
        acc     = in_valid && (q_pkt.size() < DEPTH);
        for (int j = 0; j < NUM_PE; j++)
            if (pe_idle[j] && !bank_busy[j] && !m_ov[j]) elig.push_back(j);
        hot_any = 0;
        foreach (q_pkt[i]) begin
            h = (q_wait[i] == STARVE_LIM) ||
                (replay_iter != 2'(MAX_ITER - 1) && q_pkt[i][ITER_LSB + int'(replay_iter)]);
            cand.push_back(h);
            hot_any = hot_any | h;
        end
        if (replay_iter == 2'(MAX_ITER - 1) || !hot_any)
            foreach (cand[i]) cand[i] = 1;
        m_ov  = '0;
        m_op  = '0;
        picks = 0;
        foreach (q_pkt[i]) begin
            if (cand[i] && picks < MAX_DISP && picks < elig.size()) begin
                m_ov[elig[picks]]             = 1'b1;
                m_op[elig[picks]*16 +: 16]    = q_pkt[i];
                picks++;
            end else begin
                np.push_back(q_pkt[i]);
                nw.push_back(q_wait[i] < STARVE_LIM ? q_wait[i] + 1 : STARVE_LIM);
            end
        end
        if (acc) begin
            np.push_back(in_packet);
            nw.push_back(0);
        end
        q_pkt  = np;
        q_wait = nw;
    endtask

    task automatic cycle(input logic v, input logic [15:0] p, input logic [1:0] ri,
                         input logic [3:0] idle, input logic [3:0] busy);
        in_valid    = v;
        in_packet   = p;
        replay_iter = ri;
        pe_idle     = idle;
        bank_busy   = busy;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 0; in_packet = 0; replay_iter = 0; pe_idle = 0; bank_busy = 0;
        model_clear();
        #12;
        checks++;
        if (out_valid !== 4'h0 || out_packet !== 64'h0) $display("FAIL reset_out ov=%h op=%h want 0", out_valid, out_packet);
        else passed++;
        checks++;
        if (occupancy !== 4'd0 || rs_empty !== 1'b1 || rs_full !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_status occ=%0d empty=%b full=%b rdy=%b want 0/1/0/1", occupancy, rs_empty, rs_full, in_ready);
        else passed++;
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [15:0] a;
        a = mk(3'b000);
        cycle(1, a, 0, 4'b0001, 0);
        checks++;
        if (occupancy !== 4'd1 || out_valid !== 4'h0) $display("FAIL single_enq occ=%0d ov=%b want 1/0000", occupancy, out_valid);
        else passed++;
        cycle(0, 0, 0, 4'b0001, 0);
        checks++;
        if (out_valid !== 4'b0001 || out_packet !== {48'h0, a} || occupancy !== 4'd0)
            $display("FAIL single_disp ov=%b op=%h occ=%0d want 0001/%h/0", out_valid, out_packet, occupancy, a);
        else passed++;
        cycle(0, 0, 0, 4'b0001, 0);
        checks++;
        if (out_valid !== 4'h0 || out_packet !== 64'h0) $display("FAIL single_pulse ov=%b op=%h want 0", out_valid, out_packet);
        else passed++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_pkt.size() != 0 || m_ov != 0) && n < 40) begin
            cycle(0, 0, 2'd3, 4'hF, 4'h0);
            n++;
            checks++;
            if (out_valid !== m_ov || out_packet !== m_op || occupancy !== 4'(q_pkt.size()))
                $display("FAIL drain ov=%b/%b op=%h/%h occ=%0d/%0d", out_valid, m_ov, out_packet, m_op, occupancy, q_pkt.size());
            else passed++;
        end
        checks++;
        if (rs_empty !== 1'b1 || n >= 40) $display("FAIL drain_empty empty=%b cycles=%0d want 1", rs_empty, n);
        else passed++;
    endtask

    task automatic test_full();
        logic [15:0] pk [8];
        logic [15:0] extra;
        for (int k = 0; k < 8; k++) begin
            pk[k] = mk(3'($urandom));
            cycle(1, pk[k], 0, 4'h0, 0);
        end
        checks++;
        if (rs_full !== 1'b1 || in_ready !== 1'b0 || occupancy !== 4'd8)
            $display("FAIL full_flags full=%b rdy=%b occ=%0d want 1/0/8", rs_full, in_ready, occupancy);
        else passed++;
        extra = mk(3'b000);
        cycle(1, extra, 0, 4'h0, 0);
        checks++;
        if (occupancy !== 4'd8 || in_ready !== 1'b0) $display("FAIL full_hold occ=%0d rdy=%b want 8/0", occupancy, in_ready);
        else passed++;
        cycle(1, extra, 2'd3, 4'b0001, 0);
        checks++;
        if (occupancy !== 4'd7 || in_ready !== 1'b1 || out_valid !== 4'b0001 || out_packet[15:0] !== pk[0])
            $display("FAIL full_deq occ=%0d rdy=%b ov=%b pkt=%h want 7/1/0001/%h", occupancy, in_ready, out_valid, out_packet[15:0], pk[0]);
        else passed++;
        cycle(1, extra, 0, 4'h0, 0);
        checks++;
        if (occupancy !== 4'd8 || rs_full !== 1'b1) $display("FAIL full_reenq occ=%0d full=%b want 8/1", occupancy, rs_full);
        else passed++;
        drain();
    endtask

    task automatic test_priority();
        logic [15:0] b, c, first, second;
        for (int r = 1; r <= 3; r += 2) begin
            b = mk(3'b000);
            c = mk(3'b010);
            first  = (r == 1) ? c : b;
            second = (r == 1) ? b : c;
            cycle(1, b, 2'(r), 4'h0, 0);
            cycle(1, c, 2'(r), 4'h0, 0);
            cycle(0, 0, 2'(r), 4'b0001, 0);
            checks++;
            if (out_valid !== 4'b0001 || out_packet[15:0] !== first)
                $display("FAIL prio_first iter=%0d ov=%b pkt=%h want 0001/%h", r, out_valid, out_packet[15:0], first);
            else passed++;
            cycle(0, 0, 2'(r), 4'b0001, 0);
            checks++;
            if (out_valid !== 4'h0) $display("FAIL prio_block iter=%0d ov=%b want 0000", r, out_valid);
            else passed++;
            cycle(0, 0, 2'(r), 4'b0001, 0);
            checks++;
            if (out_valid !== 4'b0001 || out_packet[15:0] !== second)
                $display("FAIL prio_second iter=%0d ov=%b pkt=%h want 0001/%h", r, out_valid, out_packet[15:0], second);
            else passed++;
        end
    endtask

    task automatic test_starve();
        logic [15:0] b;
        int          seen;
        b    = mk(3'b000);
        seen = 0;
        cycle(1, b, 1, 4'h0, 0);
        cycle(1, mk(3'b010), 1, 4'h0, 0);
        for (int n = 2; n <= 20 && seen == 0; n++) begin
            cycle(1, mk(3'b010), 1, 4'b0001, 0);
            checks++;
            if (out_valid !== m_ov || out_packet !== m_op || occupancy !== 4'(q_pkt.size()))
                $display("FAIL starve_model edge=%0d ov=%b/%b op=%h/%h", n, out_valid, m_ov, out_packet, m_op);
            else passed++;
            if (out_valid[0] && out_packet[15:0] === b) seen = n;
        end
        checks++;
        if (seen <= 2 || seen > 16) $display("FAIL starve_bound dispatched_edge=%0d want 3..16", seen);
        else passed++;
        drain();
    endtask

    task automatic test_multi();
        logic [15:0] p [4];
        for (int k = 0; k < 4; k++) begin
            p[k] = mk(3'b000);
            cycle(1, p[k], 0, 4'h0, 0);
        end
        cycle(0, 0, 0, 4'hF, 4'b0100);
        checks++;
        if (out_valid !== 4'b0011 || out_packet !== {32'h0, p[1], p[0]} || occupancy !== 4'd2)
            $display("FAIL multi_disp ov=%b op=%h occ=%0d want 0011/%h%h/2", out_valid, out_packet, occupancy, p[1], p[0]);
        else passed++;
        #2 reset = 1'b1;
        #1;
        model_clear();
        checks++;
        if (out_valid !== 4'h0 || out_packet !== 64'h0 || occupancy !== 4'd0 || rs_empty !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL midreset ov=%b op=%h occ=%0d empty=%b rdy=%b want all cleared", out_valid, out_packet, occupancy, rs_empty, in_ready);
        else passed++;
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 4'hF, 4'h0);
        checks++;
        if (out_valid !== 4'h0 || occupancy !== 4'd0) $display("FAIL post_reset ov=%b occ=%0d want 0/0", out_valid, occupancy);
        else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom), 4'($urandom), 4'($urandom & $urandom));
            checks++;
            if (out_valid !== m_ov || out_packet !== m_op || occupancy !== 4'(q_pkt.size()) ||
                in_ready !== (q_pkt.size() < DEPTH) || rs_full !== (q_pkt.size() == DEPTH) || rs_empty !== (q_pkt.size() == 0))
                $display("FAIL random cyc=%0d ov=%b/%b op=%h/%h occ=%0d/%0d", n, out_valid, m_ov, out_packet, m_op, occupancy, q_pkt.size());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_priority();
        test_starve();
        test_multi();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
